// File: rtl/ddr2_ui_pkg.sv
// ddr2_ui_pkg: shared types and constants for the DDR2 request-port to MIG UI bridge.
//   state_t       bridge FSM states
//   CMD_WRITE/READ MIG app_cmd encodings
//   LINE_W/BYTES  MIG UI line geometry (128-bit, 16 bytes)
//   TIMEOUT_DATA  word returned when a read times out
//   lane_mask()   write byte mask selecting one 32-bit word of the line
package ddr2_ui_pkg;

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, DONE} state_t;

    localparam logic [2:0]  CMD_WRITE    = 3'b000;
    localparam logic [2:0]  CMD_READ     = 3'b001;
    localparam int          LINE_W       = 128;
    localparam int          LINE_BYTES   = 16;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    // 1 = byte not written; only the four bytes of word k are enabled.
    function automatic logic [LINE_BYTES-1:0] lane_mask(input logic [1:0] k);
        return ~(16'h000F << {k, 2'b00});
    endfunction

endpackage

// File: rtl/ddr2_line_cache.sv
// ddr2_line_cache: single-line read cache for ddr2_ui_bridge (used only when
// DDR2_LINE_CACHE_EN is defined).
//   clock, reset            UI clock, synchronous active-high reset (clears valid)
//   lookup_tag, hit, line   combinational hit against the stored tag; stored line
//   fill_en/tag/line        load a whole line returned by MIG
//   wr_en/tag/data/mask     write-through merge of unmasked bytes on a tag match
import ddr2_ui_pkg::*;

module ddr2_line_cache (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [27:0]           lookup_tag,
    output logic                  hit,
    output logic [LINE_W-1:0]     line,
    input  logic                  fill_en,
    input  logic [27:0]           fill_tag,
    input  logic [LINE_W-1:0]     fill_line,
    input  logic                  wr_en,
    input  logic [27:0]           wr_tag,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic [LINE_BYTES-1:0] wr_mask
);

    logic [27:0] tag;
    logic        valid;

    assign hit = valid && (tag == lookup_tag);

    // Fill and write never coincide: the bridge has one transaction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            tag   <= '0;
            line  <= '0;
        end else if (fill_en) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            line  <= fill_line;
        end else if (wr_en && valid && (tag == wr_tag)) begin
            for (int i = 0; i < LINE_BYTES; i++)
                if (!wr_mask[i]) line[8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/ddr2_ui_bridge.sv
// ddr2_ui_bridge: converts single-word stall-handshaked DDR2 port requests into
// MIG UI transactions on 128-bit lines. Runs entirely in the UI clock domain.
//   clock, reset                 UI clock, synchronous active-high reset
//   ddr2_en/we/addr/wd           request (held stable while ddr2_stall=1)
//   ddr2_stall, ddr2_rd          completion handshake and read data
//   init_calib_complete          requests wait in IDLE until calibration is done
//   app_*                        MIG UI command / write-data / read-data ports
//   rd_timeout_err               sticky read timeout flag (RD_TIMEOUT>0 only)
// Optional: define DDR2_LINE_CACHE_EN to add a one-line write-through read cache.
import ddr2_ui_pkg::*;

module ddr2_ui_bridge #(
    parameter int APP_ADDR_W = 27,
    parameter int RD_TIMEOUT = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ddr2_en,
    input  logic                  ddr2_we,
    input  logic [31:0]           ddr2_addr,
    input  logic [31:0]           ddr2_wd,
    output logic                  ddr2_stall,
    output logic [31:0]           ddr2_rd,
    input  logic                  init_calib_complete,
    output logic [APP_ADDR_W-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [LINE_W-1:0]     app_wdf_data,
    output logic [LINE_BYTES-1:0] app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic [LINE_W-1:0]     app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  rd_timeout_err
);

    localparam logic [31:0] TMO_LAST = 32'(RD_TIMEOUT - 1);

    state_t            state;
    logic [31:0]       req_addr;
    logic              cmd_done, wd_done;
    logic [31:0]       rd_cnt;
    logic              cmd_ok, data_ok, wr_complete, rd_fill;
    logic              cache_hit;
    logic [LINE_W-1:0] cache_line;
    logic              unused_bits;

    // Combinational so the board sees stall in the request cycle itself.
    assign ddr2_stall  = ddr2_en && (state != DONE);
    assign app_wdf_end = app_wdf_wren;

    // A handshake counts as done if it completed earlier or completes this cycle.
    assign cmd_ok      = cmd_done || (app_en && app_rdy);
    assign data_ok     = wd_done || (app_wdf_wren && app_wdf_rdy);
    assign wr_complete = (state == WR) && cmd_ok && data_ok;
    assign rd_fill     = (state == RWAIT) && app_rd_data_valid;

`ifdef DDR2_LINE_CACHE_EN
    ddr2_line_cache u_cache (
        .clock      (clock),
        .reset      (reset),
        .lookup_tag (ddr2_addr[31:4]),
        .hit        (cache_hit),
        .line       (cache_line),
        .fill_en    (rd_fill),
        .fill_tag   (req_addr[31:4]),
        .fill_line  (app_rd_data),
        .wr_en      (wr_complete),
        .wr_tag     (req_addr[31:4]),
        .wr_data    (app_wdf_data),
        .wr_mask    (app_wdf_mask)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_line = '0;
`endif

    // Address bits outside the line index are only consumed by the cache.
    assign unused_bits = ^{ddr2_addr, req_addr, cache_line, rd_fill};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            req_addr       <= '0;
            app_addr       <= '0;
            app_cmd        <= CMD_WRITE;
            app_en         <= 1'b0;
            app_wdf_data   <= '0;
            app_wdf_mask   <= '1;
            app_wdf_wren   <= 1'b0;
            cmd_done       <= 1'b0;
            wd_done        <= 1'b0;
            rd_cnt         <= '0;
            ddr2_rd        <= '0;
            rd_timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ddr2_en && init_calib_complete) begin
                    req_addr     <= ddr2_addr;
                    app_addr     <= {ddr2_addr[APP_ADDR_W-1:4], 4'b0000};
                    app_wdf_data <= {4{ddr2_wd}};
                    app_wdf_mask <= lane_mask(ddr2_addr[3:2]);
                    cmd_done     <= 1'b0;
                    wd_done      <= 1'b0;
                    rd_cnt       <= '0;
                    if (ddr2_we) begin
                        app_cmd      <= CMD_WRITE;
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        state        <= WR;
                    end else if (cache_hit) begin
                        ddr2_rd <= cache_line[{ddr2_addr[3:2], 5'b0} +: 32];
                        state   <= DONE;
                    end else begin
                        app_cmd <= CMD_READ;
                        app_en  <= 1'b1;
                        state   <= RD;
                    end
                end
                WR: begin
                    if (app_en && app_rdy) begin
                        app_en   <= 1'b0;
                        cmd_done <= 1'b1;
                    end
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        wd_done      <= 1'b1;
                    end
                    if (wr_complete) state <= DONE;
                end
                RD: if (app_rdy) begin
                    app_en <= 1'b0;
                    state  <= RWAIT;
                end
                RWAIT: begin
                    if (app_rd_data_valid) begin
                        ddr2_rd <= app_rd_data[{req_addr[3:2], 5'b0} +: 32];
                        state   <= DONE;
                    end else if (RD_TIMEOUT != 0 && rd_cnt == TMO_LAST) begin
                        rd_timeout_err <= 1'b1;
                        ddr2_rd        <= TIMEOUT_DATA;
                        state          <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt + 32'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_ui_bridge.sv
// tb_ddr2_ui_bridge: directed self-checking bench for ddr2_ui_bridge.
// dut runs with RD_TIMEOUT=0; dut_to (RD_TIMEOUT=8) shares all inputs except
// its request enable and is used for the timeout case.
module tb_ddr2_ui_bridge;

    logic         clock = 0;
    logic         reset = 1;
    logic         ddr2_en = 0, en_to = 0, ddr2_we = 0;
    logic [31:0]  ddr2_addr = 0, ddr2_wd = 0;
    logic         init_calib_complete = 1;
    logic         app_rdy = 1, app_wdf_rdy = 1;
    logic [127:0] app_rd_data = 0;
    logic         app_rd_data_valid = 0;

    logic         ddr2_stall, stall_to;
    logic [31:0]  ddr2_rd, rd_to;
    logic [26:0]  app_addr, addr_to;
    logic [2:0]   app_cmd, cmd_to;
    logic         app_en, en_o_to;
    logic [127:0] app_wdf_data, wdata_to;
    logic [15:0]  app_wdf_mask, mask_to;
    logic         app_wdf_wren, wren_to, app_wdf_end, wend_to;
    logic         rd_timeout_err, err_to;

    int total = 0, bad = 0;
    int rsp_cnt = 0, rsp_lat = 2, en_cycles = 0;
    bit rsp_en = 1, force_vld = 0;

    always #5 clock = ~clock;

    ddr2_ui_bridge dut (
        .clock(clock), .reset(reset), .ddr2_en(ddr2_en), .ddr2_we(ddr2_we),
        .ddr2_addr(ddr2_addr), .ddr2_wd(ddr2_wd), .ddr2_stall(ddr2_stall), .ddr2_rd(ddr2_rd),
        .init_calib_complete(init_calib_complete), .app_addr(app_addr), .app_cmd(app_cmd),
        .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .rd_timeout_err(rd_timeout_err)
    );

    ddr2_ui_bridge #(.RD_TIMEOUT(8)) dut_to (
        .clock(clock), .reset(reset), .ddr2_en(en_to), .ddr2_we(ddr2_we),
        .ddr2_addr(ddr2_addr), .ddr2_wd(ddr2_wd), .ddr2_stall(stall_to), .ddr2_rd(rd_to),
        .init_calib_complete(init_calib_complete), .app_addr(addr_to), .app_cmd(cmd_to),
        .app_en(en_o_to), .app_rdy(app_rdy), .app_wdf_data(wdata_to),
        .app_wdf_mask(mask_to), .app_wdf_wren(wren_to), .app_wdf_end(wend_to),
        .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .rd_timeout_err(err_to)
    );

    // MIG read responder: valid pulses rsp_lat negedges after an accepted read.
    always @(negedge clock) begin
        if (app_en) en_cycles++;
        app_rd_data_valid = force_vld || (rsp_cnt == 1);
        if (rsp_cnt > 0) rsp_cnt--;
        if (rsp_en && app_en && app_rdy && app_cmd == 3'b001) rsp_cnt = rsp_lat;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        ddr2_en = 1; ddr2_we = we; ddr2_addr = addr; ddr2_wd = wd;
    endtask

    // Counts stall cycles from now until completion, returns ddr2_rd from the
    // completion cycle, then retires the request.
    task automatic wait_done(output int stalls, output logic [31:0] rd);
        bit done = 0;
        stalls = 0; rd = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (!ddr2_stall) begin
                done = 1; rd = ddr2_rd;
            end else begin
                stalls++; @(posedge clock); #1;
            end
        end
        if (!done) chk("wait_bound", 0, 1);
        @(posedge clock); #1;
        ddr2_en = 0;
    endtask

    initial begin
        int s, e0, n;
        logic [31:0] rd;

        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        chk("rst_app_en", app_en, 0);
        chk("rst_wren", app_wdf_wren, 0);
        chk("rst_err", rd_timeout_err, 0);
        chk("rst_rd", ddr2_rd, 0);
        @(posedge clock); #1;

        // write, rdy high
        drive(1, 32'h104, 32'h12345678);
        @(negedge clock); chk("t1_idle_stall", ddr2_stall, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t1_stall", ddr2_stall, 1);
        chk("t1_app_en", app_en, 1);
        chk("t1_cmd", app_cmd, 3'b000);
        chk("t1_addr", app_addr, 27'h100);
        chk("t1_mask", app_wdf_mask, 16'hFF0F);
        chk("t1_data", app_wdf_data, {4{32'h12345678}});
        chk("t1_wren", app_wdf_wren, 1);
        chk("t1_wend", app_wdf_end, 1);
        @(posedge clock); #1;
        wait_done(s, rd);
        chk("t1_stalls", 2 + s, 2);
        chk("t1_en_off", app_en, 0);

        // write with app_rdy low for 5 WR cycles
        app_rdy = 0;
        drive(1, 32'h108, 32'hA5A50001);
        @(negedge clock); chk("t2_idle_stall", ddr2_stall, 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t2_wren_first", app_wdf_wren, 1);
        chk("t2_mask", app_wdf_mask, 16'hF0FF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk("t2_wren_drop", app_wdf_wren, 0);
            chk("t2_en_hold", app_en, 1);
            chk("t2_stall_hold", ddr2_stall, 1);
        end
        @(posedge clock); #1;
        app_rdy = 1;
        wait_done(s, rd);
        chk("t2_tail_stalls", s, 1);
        chk("t2_en_off", app_en, 0);

        // read with 20-cycle MIG latency
        rsp_lat = 20;
        app_rd_data = {32'hCAFEF00D, 32'h33333333, 32'h22222222, 32'h11111111};
        drive(0, 32'h10C, 0);
        wait_done(s, rd);
        chk("t3_stalls", s, 22);
        chk("t3_rd", rd, 32'hCAFEF00D);
        repeat (3) @(posedge clock);
        #1;
        chk("t3_rd_held", ddr2_rd, 32'hCAFEF00D);
        chk("t3_no_err", rd_timeout_err, 0);

        // calibration low for 10 cycles
        init_calib_complete = 0;
        e0 = en_cycles; n = 0;
        drive(1, 32'h10, 32'h0BADF00D);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!ddr2_stall || app_en) n++;
            @(posedge clock); #1;
        end
        init_calib_complete = 1;
        chk("t4_hold_viol", n, 0);
        chk("t4_no_cmd", en_cycles - e0, 0);
        wait_done(s, rd);
        chk("t4_stalls", s, 2);
        chk("t4_addr", app_addr, 27'h10);

        // reset in RWAIT, then a stale valid
        rsp_en = 0;
        drive(0, 32'h100, 0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1; ddr2_en = 0;
        @(posedge clock); #1;
        reset = 0; force_vld = 1;
        @(negedge clock); chk("t5_en_off", app_en, 0);
        @(posedge clock); #1;
        force_vld = 0;
        @(negedge clock);
        chk("t5_rd_zero", ddr2_rd, 0);
        chk("t5_stall", ddr2_stall, 0);
        @(posedge clock); #1;
        rsp_en = 1; rsp_lat = 2;
        drive(0, 32'h104, 0);
        wait_done(s, rd);
        chk("t5_next_stalls", s, 4);
        chk("t5_next_rd", rd, 32'h22222222);

        // timeout on dut_to (RD_TIMEOUT=8): no read data ever returns
        ddr2_we = 0; ddr2_addr = 32'h100; en_to = 1;
        s = 0; n = 0;
        for (int i = 0; i < 100 && n == 0; i++) begin
            @(negedge clock);
            if (!stall_to) n = 1;
            else begin s++; @(posedge clock); #1; end
        end
        chk("t6_bound", n, 1);
        chk("t6_stalls", s, 10);
        chk("t6_err", err_to, 1);
        chk("t6_rd", rd_to, 32'hDEADBEEF);
        chk("t6_main_err", rd_timeout_err, 0);
        @(posedge clock); #1;
        en_to = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("t6_err_sticky", err_to, 1);

`ifdef DDR2_LINE_CACHE_EN
        app_rd_data = {32'h44444444, 32'h77777777, 32'h99999999, 32'h12121212};
        drive(0, 32'h200, 0);
        wait_done(s, rd);
        chk("c_miss_stalls", s, 4);
        chk("c_miss_rd", rd, 32'h12121212);
        drive(1, 32'h204, 32'h000000AA);
        wait_done(s, rd);
        chk("c_wr_stalls", s, 2);
        e0 = en_cycles;
        drive(0, 32'h204, 0);
        wait_done(s, rd);
        chk("c_hit_stalls", s, 1);
        chk("c_hit_rd", rd, 32'h000000AA);
        drive(0, 32'h208, 0);
        wait_done(s, rd);
        chk("c_hit2_rd", rd, 32'h77777777);
        chk("c_no_cmd", en_cycles - e0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
